issue_unit: RTL and testbench
=============================

ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 Clk  input  1  rising-edge clock.
REQ-002 Resetb  input  1  reset, asynchronous, active-low.
REQ-003 IssInt_Rdy  input  1  integer issue queue holds a ready entry.
REQ-004 IssMul_Rdy  input  1  multiply issue queue holds a ready entry.
REQ-005 IssDiv_Rdy  input  1  divide issue queue holds a ready entry.
REQ-006 IssLsb_Rdy  input  1  load/store buffer holds a ready entry.
REQ-007 Iss_Int  output  1  grant to integer queue, combinational, same cycle as IssInt_Rdy.
REQ-008 Iss_Mult  output  1  grant to multiply queue, combinational.
REQ-009 Iss_Div  output  1  grant to divide queue, combinational.
REQ-010 Iss_Lsb  output  1  grant to load/store buffer, combinational.
REQ-011 Iss_CdbSlotVec  output  6  current CDB reservation vector, bit k = CDB busy k+1 cycles after current cycle.
REQ-012 Iss_DivBusy  output  1  non-pipelined divider occupied.

Function
REQ-013 CDB write latency from grant cycle t SHALL be fixed: Int t+1, Lsb t+1, Mult t+4, Div t+7.
REQ-014 Reservation register Slot[5:0] SHALL shift toward bit 0 every cycle: Slot_next[k]=Slot[k+1] for k<5, Slot_next[5]=0, OR'd with new reservations.
REQ-015 Mult grant SHALL set Slot_next[2]; Div grant SHALL set Slot_next[5]; Int/Lsb grants set no bit (consumed next cycle).
REQ-016 Iss_Div SHALL assert iff IssDiv_Rdy && !Iss_DivBusy (Div slot never pre-reserved by construction).
REQ-017 Iss_Mult SHALL assert iff IssMul_Rdy && !Slot[3].
REQ-018 Int/Lsb eligibility SHALL require !Slot[0]; at most one of Iss_Int, Iss_Lsb per cycle.
REQ-019 Int/Lsb tie (both ready, Slot[0]=0) SHALL grant the one not granted most recently, tracked by 1-bit LRU register; single requester granted directly.
REQ-020 LRU register SHALL update only on an Int or Lsb grant, recording the granted requester.
REQ-021 Div, Mult and one of Int/Lsb MAY be granted in the same cycle (distinct CDB cycles guaranteed).
REQ-022 Divider busy counter (3 bits) SHALL load 6 on Div grant and decrement to 0; Iss_DivBusy = (count!=0); a Div request is next grantable 7 cycles after the previous grant.
REQ-023 No grant SHALL assert without its Rdy input; grants with Rdy=0 create no reservation.
REQ-024 Flush (ROB) SHALL NOT clear reservations or divider counter; flushed ops still consume their CDB cycle.
REQ-025 Iss_CdbSlotVec SHALL equal Slot register directly (registered, no combinational path).

Reset
REQ-026 Resetb=0 SHALL asynchronously clear Slot to 6'b0, divider counter to 0, LRU to "Lsb last" (Int wins first tie).
REQ-027 During and immediately after reset all grant outputs SHALL be 0 unless a Rdy input is high after release, in which case normal rules apply with empty reservations.
REQ-028 Reset asserted mid-operation SHALL discard all pending reservations and divider occupancy.

Verification
REQ-029 After reset, IssInt_Rdy=IssLsb_Rdy=1 for 3 cycles -> grants Int, Lsb, Int; never both in one cycle.
REQ-030 IssMul_Rdy=1 at t, IssInt_Rdy=1 at t+3 -> Iss_Mult at t, Slot[0]=1 at t+3, Iss_Int=0 at t+3, Iss_Int=1 at t+4.
REQ-031 IssDiv_Rdy held high from t -> Iss_Div at t and t+7 only; Iss_DivBusy=1 for t+1..t+6.
REQ-032 IssDiv_Rdy at t, IssMul_Rdy held from t+3 -> Iss_Mult blocked at t+3 (Slot[3]=1), granted at t+4.
REQ-033 All four Rdy high at cycle 0 after reset -> Iss_Div=Iss_Mult=Iss_Int=1, Iss_Lsb=0, Iss_CdbSlotVec=6'b100100 next cycle.
REQ-034 Resetb pulsed low with Slot=6'b101000 -> Slot=0 and Iss_DivBusy=0 immediately, no clock required.

Source files
------------

// File: rtl/issue_unit_if.sv
// Issue handshake between the issue queues and the issue unit.
// master = issue-queue side (drives ready flags); slave = issue unit (drives grants and status).
interface issue_unit_if;
    logic       IssInt_Rdy;
    logic       IssMul_Rdy;
    logic       IssDiv_Rdy;
    logic       IssLsb_Rdy;
    logic       Iss_Int;
    logic       Iss_Mult;
    logic       Iss_Div;
    logic       Iss_Lsb;
    logic [5:0] Iss_CdbSlotVec;
    logic       Iss_DivBusy;

    modport master (
        output IssInt_Rdy, IssMul_Rdy, IssDiv_Rdy, IssLsb_Rdy,
        input  Iss_Int, Iss_Mult, Iss_Div, Iss_Lsb, Iss_CdbSlotVec, Iss_DivBusy
    );

    modport slave (
        input  IssInt_Rdy, IssMul_Rdy, IssDiv_Rdy, IssLsb_Rdy,
        output Iss_Int, Iss_Mult, Iss_Div, Iss_Lsb, Iss_CdbSlotVec, Iss_DivBusy
    );
endinterface

// File: rtl/issue_unit.sv
// Issue arbiter: grants functional-unit queues so that no two results ever collide
// on the CDB, using a shifting reservation vector plus a non-pipelined divider counter.
module issue_unit (
    input  logic         Clk,
    input  logic         Resetb,
    issue_unit_if.slave  iss
);
    logic [5:0] slotReg;
    logic [5:0] slotShift;
    logic [5:0] slotNext;
    logic [2:0] divCountReg;
    logic [2:0] divCountNext;
    logic       lruLsbReg;      // 1: Lsb was the most recent Int/Lsb grant
    logic       lruLsbNext;
    logic       divBusy;
    logic       grantInt;
    logic       grantMult;
    logic       grantDiv;
    logic       grantLsb;

    // Reservation vector ages by one cycle every clock.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_shift
            assign slotShift[gi] = slotReg[gi + 1];
        end
    endgenerate
    assign slotShift[5] = 1'b0;

    assign divBusy = (divCountReg != 3'd0);

    always_comb begin
        grantInt  = 1'b0;
        grantLsb  = 1'b0;
        grantDiv  = iss.IssDiv_Rdy & ~divBusy;
        // Slot[3] now becomes Slot[2] next cycle, exactly the bit a multiply would claim.
        grantMult = iss.IssMul_Rdy & ~slotReg[3];
        if (!slotReg[0]) begin
            if (iss.IssInt_Rdy && iss.IssLsb_Rdy) begin
                grantInt = lruLsbReg;
                grantLsb = ~lruLsbReg;
            end else begin
                grantInt = iss.IssInt_Rdy;
                grantLsb = iss.IssLsb_Rdy;
            end
        end
    end

    always_comb begin
        slotNext     = slotShift | {grantDiv, 2'b00, grantMult, 2'b00};
        divCountNext = divCountReg;
        if (grantDiv) begin
            divCountNext = 3'd6;
        end else if (divBusy) begin
            divCountNext = divCountReg - 3'd1;
        end
        lruLsbNext = lruLsbReg;
        if (grantLsb) begin
            lruLsbNext = 1'b1;
        end else if (grantInt) begin
            lruLsbNext = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            slotReg     <= 6'b000000;
            divCountReg <= 3'd0;
            lruLsbReg   <= 1'b1;
        end else begin
            slotReg     <= slotNext;
            divCountReg <= divCountNext;
            lruLsbReg   <= lruLsbNext;
        end
    end

    assign iss.Iss_Int        = grantInt;
    assign iss.Iss_Mult       = grantMult;
    assign iss.Iss_Div        = grantDiv;
    assign iss.Iss_Lsb        = grantLsb;
    assign iss.Iss_CdbSlotVec = slotReg;
    assign iss.Iss_DivBusy    = divBusy;
endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: each cycle's expected grants/slot vector/busy flag are queued
// when stimulus is driven and compared against the DUT mid-cycle.
module tb_issue_unit;
    logic Clk = 1'b0;
    logic Resetb;

    issue_unit_if bus ();

    issue_unit dut (
        .Clk    (Clk),
        .Resetb (Resetb),
        .iss    (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      tag;
        logic [3:0] grant;   // {Int, Mult, Div, Lsb}
        logic [5:0] slot;
        logic       busy;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic drive(input logic [3:0] rdy);
        bus.IssInt_Rdy = rdy[3];
        bus.IssMul_Rdy = rdy[2];
        bus.IssDiv_Rdy = rdy[1];
        bus.IssLsb_Rdy = rdy[0];
    endtask

    task automatic expect_push(input string tag, input logic [3:0] g, input logic [5:0] s, input logic b);
        exp_t e;
        e.tag   = tag;
        e.grant = g;
        e.slot  = s;
        e.busy  = b;
        sbq.push_back(e);
    endtask

    task automatic compare_next();
        exp_t       e;
        logic [3:0] got;
        e   = sbq.pop_front();
        got = {bus.Iss_Int, bus.Iss_Mult, bus.Iss_Div, bus.Iss_Lsb};
        compared++;
        assert (got === e.grant) else begin
            mismatched++;
            $error("FAIL %s grants: observed %b expected %b", e.tag, got, e.grant);
        end
        compared++;
        assert (bus.Iss_CdbSlotVec === e.slot) else begin
            mismatched++;
            $error("FAIL %s slotvec: observed %b expected %b", e.tag, bus.Iss_CdbSlotVec, e.slot);
        end
        compared++;
        assert (bus.Iss_DivBusy === e.busy) else begin
            mismatched++;
            $error("FAIL %s divbusy: observed %b expected %b", e.tag, bus.Iss_DivBusy, e.busy);
        end
        compared++;
        assert ((bus.Iss_Int & bus.Iss_Lsb) === 1'b0) else begin
            mismatched++;
            $error("FAIL %s int_lsb_exclusive: observed Int=%b Lsb=%b expected not both", e.tag, bus.Iss_Int, bus.Iss_Lsb);
        end
        $display("cycle %-8s rdy=%b%b%b%b grant=%b slot=%b busy=%b", e.tag, bus.IssInt_Rdy, bus.IssMul_Rdy,
                 bus.IssDiv_Rdy, bus.IssLsb_Rdy, got, bus.Iss_CdbSlotVec, bus.Iss_DivBusy);
    endtask

    // One clock cycle: drive at start, compare at the falling edge, advance past the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] rdy, input logic [3:0] g, input logic [5:0] s, input logic b);
        drive(rdy);
        expect_push(tag, g, s, b);
        @(negedge Clk);
        compare_next();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        Resetb = 1'b0;
        drive(4'b0000);
        #3;
        expect_push("reset", 4'b0000, 6'b000000, 1'b0);
        compare_next();
        @(posedge Clk);
        #1;
        Resetb = 1'b1;

        // All four ready on the first cycle out of reset.
        cyc("all4",   4'b1111, 4'b1110, 6'b000000, 1'b0);
        cyc("drainB", 4'b0000, 4'b0000, 6'b100100, 1'b1);
        cyc("drainC", 4'b0000, 4'b0000, 6'b010010, 1'b1);
        cyc("drainD", 4'b0000, 4'b0000, 6'b001001, 1'b1);
        cyc("drainE", 4'b0000, 4'b0000, 6'b000100, 1'b1);
        cyc("drainF", 4'b0000, 4'b0000, 6'b000010, 1'b1);
        cyc("drainG", 4'b0000, 4'b0000, 6'b000001, 1'b1);
        cyc("drainH", 4'b0000, 4'b0000, 6'b000000, 1'b0);

        // Int was granted last, so the next tie goes to Lsb.
        cyc("tieLsb", 4'b1001, 4'b0001, 6'b000000, 1'b0);
        cyc("tieInt", 4'b1001, 4'b1000, 6'b000000, 1'b0);

        // Build up state, then reset asynchronously mid-cycle.
        cyc("divA",   4'b0010, 4'b0010, 6'b000000, 1'b0);
        cyc("mulA",   4'b0100, 4'b0100, 6'b100000, 1'b1);
        drive(4'b0000);
        expect_push("preRst", 4'b0000, 6'b010100, 1'b1);
        @(negedge Clk);
        compare_next();
        #1;
        Resetb = 1'b0;
        #1;
        expect_push("midRst", 4'b0000, 6'b000000, 1'b0);
        compare_next();
        @(posedge Clk);
        #1;
        Resetb = 1'b1;

        // Fresh LRU after reset: Int, Lsb, Int.
        cyc("tie1",   4'b1001, 4'b1000, 6'b000000, 1'b0);
        cyc("tie2",   4'b1001, 4'b0001, 6'b000000, 1'b0);
        cyc("tie3",   4'b1001, 4'b1000, 6'b000000, 1'b0);

        // Multiply result blocks an integer issue three cycles later.
        cyc("mul30",  4'b0100, 4'b0100, 6'b000000, 1'b0);
        cyc("wait1",  4'b0000, 4'b0000, 6'b000100, 1'b0);
        cyc("wait2",  4'b0000, 4'b0000, 6'b000010, 1'b0);
        cyc("intBlk", 4'b1000, 4'b0000, 6'b000001, 1'b0);
        cyc("intGo",  4'b1000, 4'b1000, 6'b000000, 1'b0);

        // Divide held high; multiply collides with the divide slot at t+3.
        cyc("div0",   4'b0010, 4'b0010, 6'b000000, 1'b0);
        cyc("div1",   4'b0010, 4'b0000, 6'b100000, 1'b1);
        cyc("div2",   4'b0010, 4'b0000, 6'b010000, 1'b1);
        cyc("mulBlk", 4'b0110, 4'b0000, 6'b001000, 1'b1);
        cyc("mulGo",  4'b0110, 4'b0100, 6'b000100, 1'b1);
        cyc("div5",   4'b0010, 4'b0000, 6'b000110, 1'b1);
        cyc("div6",   4'b0010, 4'b0000, 6'b000011, 1'b1);
        cyc("div7",   4'b0011, 4'b0010, 6'b000001, 1'b0);
        cyc("div8",   4'b0010, 4'b0000, 6'b100000, 1'b1);
        drive(4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
